// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
// Shared constants for the data-memory MMIO responder: default peripheral
// base address, register word offsets (addr[7:2]) and STATUS bit positions.
// ----------------------------------------------------------------------------
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0000;

  // Word offsets, compared against addr[7:2]
  localparam logic [5:0] OFF_TX_DATA  = 6'h00;  // byte 0x00
  localparam logic [5:0] OFF_STATUS   = 6'h01;  // byte 0x04
  localparam logic [5:0] OFF_CYCLE_LO = 6'h02;  // byte 0x08
  localparam logic [5:0] OFF_CYCLE_HI = 6'h03;  // byte 0x0C
  localparam logic [5:0] OFF_GPIO     = 6'h04;  // byte 0x10

  // STATUS register layout
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/tx_fifo.sv
// ----------------------------------------------------------------------------
// tx_fifo
// Byte FIFO for the TX path. No fall-through: a byte pushed into an empty
// FIFO appears at head one cycle later. A push while full is accepted only
// if a pop happens in the same cycle; otherwise it is dropped and push_drop
// pulses for that cycle.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, push_data write request and byte
//   pop             remove head (caller guarantees !empty)
//   head            head byte, 0 while empty
//   empty, full     occupancy flags
//   count           number of stored bytes, 0..DEPTH
//   push_drop       push refused this cycle
// ----------------------------------------------------------------------------
module tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          push_drop
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop_ok    = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && !push_ok;
  // Gate the head so the output is a clean 0 after reset instead of
  // whatever the uninitialised storage holds.
  assign head      = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// dmem_mmio_responder
// Sits on the core's data-memory port and splits each access between the data
// BRAM and a 256-byte peripheral register bank (TX FIFO, 64-bit cycle counter,
// GPIO). Register reads return one cycle later, matching BRAM latency.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   addr, re, we     core access (byte address, load, byte write enables)
//   wdata            lane-aligned store data
//   rdata            load data, valid the cycle after the access
//   bram_we          byte enables to the BRAM (zeroed for register accesses)
//   bram_dout        BRAM read data (1-cycle latency)
//   tx_data/valid    FIFO head byte / non-empty
//   tx_ready         downstream consumes head this cycle
//   gpio_out         GPIO output register
// ----------------------------------------------------------------------------
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE     = DEFAULT_BASE,
  parameter int          TX_DEPTH = 16,
  parameter int          GPIO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [3:0]        bram_we,
  input  logic [31:0]       bram_dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic              sel;
  logic [5:0]        off;
  logic              rd;
  logic              sel_q;
  logic [31:0]       prd_q;
  logic [31:0]       reg_rdata;
  logic [63:0]       cnt;
  logic [31:0]       hi_shadow;
  logic              overflow;
  logic [GPIO_W-1:0] gpio_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              fifo_drop;
  logic              ovf_clr;

  // Byte-within-word bits and high store lanes are not part of any register.
  logic              unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign sel     = (addr[31:8] == BASE[31:8]);
  assign off     = addr[7:2];
  assign rd      = re && sel;
  assign bram_we = sel ? 4'b0000 : we;

  assign fifo_push = sel && (off == OFF_TX_DATA) && we[0];
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;
  assign ovf_clr   = sel && (off == OFF_STATUS) && we[0] && wdata[ST_OVERFLOW];

  tx_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(wdata[7:0]),
    .pop      (fifo_pop),
    .head     (tx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .push_drop(fifo_drop)
  );

  // GPIO byte-lane merge; lanes beyond GPIO_W simply have no bits to touch.
  always_comb begin
    gpio_d = gpio_out;
    if (sel && (off == OFF_GPIO)) begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (we[i / 8]) gpio_d[i] = wdata[i];
      end
    end
  end

  // Register read value, reflecting state before this cycle's updates.
  always_comb begin
    reg_rdata = 32'h0;
    case (off)
      OFF_STATUS: begin
        reg_rdata[ST_FULL]                = fifo_full;
        reg_rdata[ST_EMPTY]               = fifo_empty;
        reg_rdata[ST_OVERFLOW]            = overflow;
        reg_rdata[ST_COUNT_LSB +: CW]     = fifo_count;
      end
      OFF_CYCLE_LO: reg_rdata = cnt[31:0];
      OFF_CYCLE_HI: reg_rdata = hi_shadow;
      OFF_GPIO:     reg_rdata = 32'(gpio_out);
      default:      reg_rdata = 32'h0;
    endcase
  end

  assign rdata = sel_q ? prd_q : bram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      prd_q     <= 32'h0;
      cnt       <= 64'h0;
      hi_shadow <= 32'h0;
      overflow  <= 1'b0;
      gpio_out  <= '0;
    end else begin
      sel_q    <= rd;
      cnt      <= cnt + 64'd1;
      gpio_out <= gpio_d;
      if (rd) prd_q <= reg_rdata;
      // Reading LO snapshots HI so a later HI read pairs with it atomically.
      if (rd && (off == OFF_CYCLE_LO)) hi_shadow <= cnt[63:32];
      // A dropped push in the same cycle as a clear keeps the flag set.
      if (fifo_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  gpio_out;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .BASE(BASE), .TX_DEPTH(16), .GPIO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .bram_we(bram_we), .bram_dout(bram_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .gpio_out(gpio_out)
  );

  // Simple BRAM model: read-before-write, 1-cycle latency, no reset.
  always @(posedge clk) begin
    bram_dout <= mem[addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (bram_we[b]) mem[addr[7:2]][8*b +: 8] <= wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic [3:0] exp_bwe, input string tag);
    addr = a; wdata = d; we = w; re = 1'b0;
    #1 chk(tag, 64'(bram_we), 64'(exp_bwe));
    @(negedge clk);
    we = 4'h0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1; we = 4'h0;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a_lo;
    logic [31:0] b_lo;

    for (int i = 0; i < 64; i++) mem[i] = 32'hB000_0000 | i;
    rst_n = 1'b0; addr = 32'h0; re = 1'b0; we = 4'h0; wdata = 32'h0; tx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_rdata_bram", 64'(rdata), 64'h0000_0000_B000_0000);
    chk("rst_tx_valid",   64'(tx_valid), 64'h0);
    chk("rst_tx_data",    64'(tx_data), 64'h0);
    chk("rst_gpio",       64'(gpio_out), 64'h0);
    rst_n = 1'b1;
    tick();

    load(BASE + 32'h04, r);
    chk("status_after_rst", 64'(r), 64'h2);
    load(BASE + 32'h0C, r);
    chk("cycle_hi_rst", 64'(r), 64'h0);

    // Plain BRAM store / load
    store(32'h0000_0040, 32'h1234_5678, 4'hF, 4'hF, "bram_store_we");
    load(32'h0000_0040, r);
    chk("bram_load", 64'(r), 64'h1234_5678);

    // Two pushes, no fall-through
    addr = BASE; wdata = 32'h41; we = 4'b0001;
    #1 chk("push_bram_we", 64'(bram_we), 64'h0);
    chk("no_fallthrough", 64'(tx_valid), 64'h0);
    tick();
    chk("valid_after_push", 64'(tx_valid), 64'h1);
    chk("head_0x41", 64'(tx_data), 64'h41);
    wdata = 32'h42;
    tick();
    we = 4'h0;
    load(BASE + 32'h04, r);
    chk("status_cnt2", 64'(r), 64'h0000_0200);
    tx_ready = 1'b1;
    #1 chk("drain_0x41", 64'(tx_data), 64'h41);
    tick();
    chk("drain_0x42", 64'(tx_data), 64'h42);
    chk("drain_valid", 64'(tx_valid), 64'h1);
    tick();
    chk("drained_empty", 64'(tx_valid), 64'h0);
    tx_ready = 1'b0;

    // Overflow: 17 pushes into a 16-deep FIFO
    addr = BASE; we = 4'b0001;
    for (int i = 0; i < 17; i++) begin
      wdata = 32'h60 + i;
      tick();
    end
    we = 4'h0;
    load(BASE + 32'h04, r);
    chk("status_full_ovf", 64'(r), 64'h0000_1005);
    chk("head_after_ovf", 64'(tx_data), 64'h60);
    store(BASE + 32'h04, 32'h4, 4'b0001, 4'h0, "w1c_bram_we");
    load(BASE + 32'h04, r);
    chk("status_ovf_clr", 64'(r), 64'h0000_1001);

    // Full with simultaneous pop: push accepted
    addr = BASE; wdata = 32'h99; we = 4'b0001; tx_ready = 1'b1;
    tick();
    we = 4'h0; tx_ready = 1'b0;
    load(BASE + 32'h04, r);
    chk("status_push_pop_full", 64'(r), 64'h0000_1001);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 chk("drain_order", 64'(tx_data), (i < 15) ? 64'(32'h61 + i) : 64'h99);
      tick();
    end
    chk("drain_all_empty", 64'(tx_valid), 64'h0);
    tx_ready = 1'b0;

    // Counter: LO/HI snapshot across a carry
    addr = BASE + 32'h08; re = 1'b1;
    force dut.cnt = 64'h0000_0001_FFFF_FFFF;
    tick();
    release dut.cnt;
    re = 1'b0;
    chk("cycle_lo_forced", 64'(rdata), 64'hFFFF_FFFF);
    tick();
    tick();
    load(BASE + 32'h0C, r);
    chk("cycle_hi_shadow", 64'(r), 64'h1);
    // Non-load accesses to CYCLE_LO must not re-latch the shadow
    store(BASE + 32'h08, 32'h0, 4'hF, 4'h0, "cycle_lo_w_bram_we");
    load(BASE + 32'h0C, r);
    chk("cycle_hi_no_relatch", 64'(r), 64'h1);
    load(BASE + 32'h08, a_lo);
    repeat (4) tick();
    load(BASE + 32'h08, b_lo);
    chk("cycle_delta", 64'(b_lo - a_lo), 64'd5);

    // GPIO
    store(BASE + 32'h10, 32'h0000_ABCD, 4'b0011, 4'h0, "gpio_bram_we");
    chk("gpio_sh", 64'(gpio_out), 64'hCD);
    load(BASE + 32'h10, r);
    chk("gpio_readback", 64'(r), 64'h0000_00CD);
    store(BASE + 32'h10, 32'h0000_FF00, 4'b0010, 4'h0, "gpio_hi_lane_bram_we");
    chk("gpio_hi_lane", 64'(gpio_out), 64'hCD);
    store(BASE + 32'h10, 32'h0000_005A, 4'b0001, 4'h0, "gpio_lane0_bram_we");
    chk("gpio_lane0", 64'(gpio_out), 64'h5A);
    load(BASE + 32'h20, r);
    chk("unmapped_read", 64'(r), 64'h0);
    load(BASE + 32'h00, r);
    chk("tx_data_read", 64'(r), 64'h0);

    // Reset in the middle of a register load
    addr = BASE + 32'h10; re = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_gpio_async", 64'(gpio_out), 64'h0);
    tick();
    re = 1'b0;
    chk("rst_inflight_bram", 64'(rdata), 64'h0000_0000_B000_0004);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
